// File: rtl/stage_sequencer.sv
// stage_sequencer: game-flow FSM (title -> stage -> result -> shop -> next stage / game-over / win),
// score and money accumulation, shop purchase arbitration. Optional STAGE_SKIP_EN adds skipKey.
module stage_sequencer #(
  parameter int          NUM_LEVELS     = 4,
  parameter logic [19:0] TARGET_BASE    = 20'd500,
  parameter logic [19:0] TARGET_STEP    = 20'd300,
  parameter int          RESULT_SECONDS = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        oneSecPulse,
  input  logic        startKey,
  input  logic        shopDoneKey,
  input  logic        stageEnded,
  input  logic        stagePassed,
  input  logic [19:0] scoreIncrease,
  input  logic        purchaseReq,
  input  logic [19:0] purchaseCost,
`ifdef STAGE_SKIP_EN
  input  logic        skipKey,
`endif
  output logic        stageEnable,
  output logic [2:0]  levelIndex,
  output logic [19:0] score,
  output logic [19:0] money,
  output logic [19:0] target,
  output logic [2:0]  gameState,
  output logic        purchaseAck,
  output logic        purchaseDenied
);

  localparam int TW = $clog2(RESULT_SECONDS + 2);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOAD      = 3'd1,
    S_PLAY      = 3'd2,
    S_RESULT    = 3'd3,
    S_SHOP      = 3'd4,
    S_GAME_OVER = 3'd5,
    S_WIN       = 3'd6
  } state_t;

  state_t        r_state;
  logic          r_stage_enable;
  logic [2:0]    r_level;
  logic [19:0]   r_score;
  logic [19:0]   r_money;
  logic [TW-1:0] r_timer;
  logic          r_ack;
  logic          r_deny;

  state_t        w_state_next;
  logic [2:0]    w_level_next;
  logic [19:0]   w_score_next;
  logic [19:0]   w_money_next;
  logic [TW-1:0] w_timer_next;
  logic          w_ack_next;
  logic          w_deny_next;
  logic          w_passed;
  logic          w_skip;
  logic          w_last;
  logic [20:0]   w_score_sum;
  logic [20:0]   w_money_sum;
  logic [19:0]   w_target;

`ifdef STAGE_SKIP_EN
  assign w_skip = skipKey;
`else
  assign w_skip = 1'b0;
`endif

  assign w_target    = TARGET_BASE + 20'(r_level) * TARGET_STEP;
  assign w_last      = (r_level == 3'(NUM_LEVELS - 1));
  assign w_score_sum = {1'b0, r_score} + {1'b0, scoreIncrease};
  assign w_money_sum = {1'b0, r_money} + {1'b0, scoreIncrease};

  always_comb begin
    w_state_next = r_state;
    w_level_next = r_level;
    w_score_next = r_score;
    w_money_next = r_money;
    w_timer_next = r_timer;
    w_ack_next   = 1'b0;
    w_deny_next  = 1'b0;
    w_passed     = 1'b0;
    case (r_state)
      S_IDLE, S_GAME_OVER, S_WIN: begin
        if (startKey) begin
          w_score_next = '0;
          w_money_next = '0;
          w_level_next = '0;
          w_state_next = S_LOAD;
        end
      end
      S_LOAD: w_state_next = S_PLAY;
      S_PLAY: begin
        // A skip ends the stage as passed without crediting that cycle's score.
        if (w_skip) begin
          w_passed = 1'b1;
        end else if (scoreIncrease != '0) begin
          w_score_next = w_score_sum[20] ? 20'hFFFFF : w_score_sum[19:0];
          w_money_next = w_money_sum[20] ? 20'hFFFFF : w_money_sum[19:0];
        end
        if (!w_skip && stageEnded)
          w_passed = stagePassed || (w_score_next >= w_target);
        if (w_skip || stageEnded) begin
          if (w_passed && w_last) begin
            w_state_next = S_WIN;
          end else if (w_passed) begin
            w_state_next = S_RESULT;
            w_timer_next = TW'(RESULT_SECONDS);
          end else begin
            w_state_next = S_GAME_OVER;
          end
        end
      end
      S_RESULT: begin
        if (oneSecPulse) begin
          if (r_timer <= TW'(1)) begin
            w_timer_next = '0;
            w_state_next = S_SHOP;
          end else begin
            w_timer_next = r_timer - TW'(1);
          end
        end
      end
      S_SHOP: begin
        // A purchase wins over a simultaneous leave request, which is dropped.
        if (purchaseReq) begin
          if (r_money >= purchaseCost) begin
            w_money_next = r_money - purchaseCost;
            w_ack_next   = 1'b1;
          end else begin
            w_deny_next  = 1'b1;
          end
        end else if (shopDoneKey) begin
          w_level_next = r_level + 3'd1;
          w_state_next = S_LOAD;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_stage_enable <= 1'b0;
      r_level        <= '0;
      r_score        <= '0;
      r_money        <= '0;
      r_timer        <= '0;
      r_ack          <= 1'b0;
      r_deny         <= 1'b0;
    end else begin
      r_state        <= w_state_next;
      r_stage_enable <= (w_state_next == S_PLAY);
      r_level        <= w_level_next;
      r_score        <= w_score_next;
      r_money        <= w_money_next;
      r_timer        <= w_timer_next;
      r_ack          <= w_ack_next;
      r_deny         <= w_deny_next;
    end
  end

  assign stageEnable    = r_stage_enable;
  assign levelIndex     = r_level;
  assign score          = r_score;
  assign money          = r_money;
  assign target         = w_target;
  assign gameState      = r_state;
  assign purchaseAck    = r_ack;
  assign purchaseDenied = r_deny;

endmodule

// File: doc/stage_sequencer.md
Name: stage_sequencer

Overview:
Top-level game-flow controller. It is the consumer end of the level controller's stage interface. It drives the stage-enable level that starts each stage, consumes stageEnded/stagePassed/scoreIncrease, and accumulates score and money. It also sequences title -> stage -> result -> shop -> next stage, ending in game-over or win, and arbitrates shop purchases against money.

Parameters:
NUM_LEVELS, 4, number of stages; passing stage NUM_LEVELS-1 wins
TARGET_BASE, 20'd500, score target for level 0
TARGET_STEP, 20'd300, target increment per level
RESULT_SECONDS, 3, result-screen hold time in oneSecPulse ticks

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
oneSecPulse  in  1  one-cycle tick per second
startKey  in  1  one-cycle start request
shopDoneKey  in  1  one-cycle leave-shop request
stageEnded  in  1  stage over (level controller)
stagePassed  in  1  all objects collected (level controller)
scoreIncrease  in  20  per-cycle score delta; 0 = none
purchaseReq  in  1  one-cycle buy request
purchaseCost  in  20  cost, sampled with purchaseReq
stageEnable  out  1  level high while a stage is active
levelIndex  out  3  current level, 0..NUM_LEVELS-1
score  out  20  accumulated score
money  out  20  spendable money
target  out  20  TARGET_BASE + levelIndex*TARGET_STEP (combinational)
gameState  out  3  IDLE=0 LOAD=1 PLAY=2 RESULT=3 SHOP=4 GAME_OVER=5 WIN=6
purchaseAck  out  1  one-cycle: purchase accepted
purchaseDenied  out  1  one-cycle: purchase refused

Behaviour:
- Reset values: state IDLE, stageEnable 0, levelIndex 0, score 0, money 0, purchaseAck 0, purchaseDenied 0, result timer 0. Reset asserted mid-stage aborts immediately to these values.
- All outputs except target are registered.
- IDLE / GAME_OVER / WIN, on startKey: clear score, money and levelIndex; go to LOAD next cycle.
- LOAD: stageEnable = 0 for exactly one cycle, then go to PLAY. This guarantees a 0->1 enable edge between consecutive stages.
- PLAY: stageEnable = 1.
  - Every cycle with scoreIncrease != 0: score += scoreIncrease and money += scoreIncrease. Both saturate at 20'hFFFFF.
  - On the first cycle with stageEnded = 1, set stageEnable = 0 on the next edge.
  - passed = stagePassed OR (score_next >= target). score_next includes the same-cycle scoreIncrease.
  - passed and levelIndex == NUM_LEVELS-1 -> WIN.
  - passed otherwise -> RESULT; load the result timer with RESULT_SECONDS.
  - not passed -> GAME_OVER.
- RESULT: the timer decrements on each oneSecPulse. Leaving happens in the same cycle the pulse finds timer == 1; go to SHOP. A pulse arriving in the entry cycle counts.
- SHOP, on purchaseReq:
  - If money >= purchaseCost: money -= purchaseCost; purchaseAck = 1 for one cycle, on the next edge.
  - Otherwise money is unchanged and purchaseDenied = 1 for one cycle.
  - Cost 0 is always acknowledged.
- SHOP, on shopDoneKey: levelIndex += 1; go to LOAD.
- SHOP, purchaseReq and shopDoneKey in the same cycle: process the purchase first and stay in SHOP. The shopDoneKey is dropped.
- purchaseReq outside SHOP: ignored; no ack or deny.
- startKey outside IDLE / GAME_OVER / WIN: ignored.
- shopDoneKey outside SHOP: ignored.
- scoreIncrease outside PLAY: ignored. This covers the residual pulse in the cycle after stageEnded.
- stageEnded in LOAD: ignored. stageEnable is low there, so the level controller's deassert-cycle value is stale.
- The target multiply is at most 3x20 bits. Overflow wraps; parameter choice must keep it in range.

Optional Feature:
Macro: STAGE_SKIP_EN.
- Defined: adds input skipKey (1 bit). skipKey in PLAY is treated as stageEnded with passed forced to 1, so it advances to RESULT, or to WIN on the last level. Score and money are unchanged by the skip.
- Undefined: no skipKey port; behaviour is exactly as above.

Test Plan:
1. reset, startKey -> gameState 0->1->2; stageEnable low exactly one cycle in LOAD then high; levelIndex 0, score 0.
2. PLAY, scoreIncrease 20'd300 then 20'd250, then stageEnded (stagePassed 0) -> score 550 >= target 500, gameState 3. After 3 oneSecPulse -> gameState 4; money 550.
3. SHOP, money 550: purchaseReq with cost 200 -> purchaseAck, money 350. Then cost 400 -> purchaseDenied, money 350. Then shopDoneKey -> levelIndex 1, target 800, stageEnable 0 for one cycle then 1.
4. Level 1, score 550, stageEnded with stagePassed 0 and scoreIncrease 0 -> gameState 5 (GAME_OVER). startKey -> score 0, money 0, levelIndex 0, gameState 1.
5. Score 20'hFFFF0 + scoreIncrease 20'h100 -> score 20'hFFFFF (saturated). Level 3 with stagePassed -> gameState 6 (WIN).
6. Reset asserted in PLAY with score 123 -> all outputs at reset values immediately, asynchronously.
